// File: rtl/packet_pkg.sv
// Shared types and constants for the packet transmit path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Optional feature macro: PACKET_TX_CHECK_EN (adds a fifth XOR checksum beat).
package packet_pkg;

  localparam int HEADER_W = 16;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int BEAT_W   = 16;

`ifdef PACKET_TX_CHECK_EN
  localparam int NUM_BEATS = 5;
  localparam int BIDX_W    = 3;
`else
  localparam int NUM_BEATS = 4;
  localparam int BIDX_W    = 2;
`endif

  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(NUM_BEATS - 1);

  typedef struct packed {
    logic [HEADER_W-1:0] header;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
  } packet_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // Beat order on the link: header, addr, data high half, data low half,
  // then (when enabled) the XOR of the four previous beats.
  function automatic logic [BEAT_W-1:0] beat_of(input packet_t p,
                                                input logic [BIDX_W-1:0] idx);
    logic [BEAT_W-1:0] b;
    b = '0;
    case (idx)
      BIDX_W'(0): b = p.header;
      BIDX_W'(1): b = p.addr;
      BIDX_W'(2): b = p.data[31:16];
      BIDX_W'(3): b = p.data[15:0];
`ifdef PACKET_TX_CHECK_EN
      BIDX_W'(4): b = p.header ^ p.addr ^ p.data[31:16] ^ p.data[15:0];
`endif
      default:    b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/packet_tx_serializer.sv
// Serializes one header/addr/data packet into 16-bit link beats with a last marker.
// Latency: first (header) beat is valid 1 cycle after the packet handshake.
// Backpressure: link beats hold while link_ready=0; a new packet is taken only
//   in IDLE or alongside acceptance of the current last beat (no bubble).
// Ports: clock/reset (sync, active-high); inPacket_* valid/ready packet input;
//   link_* valid/ready beat output with link_last; busy; sent_count (wrapping).
// Optional feature macro: PACKET_TX_CHECK_EN (fifth XOR checksum beat).
module packet_tx_serializer
  import packet_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inPacket_valid,
  output logic                inPacket_ready,
  input  logic [15:0]         inPacket_tx_header,
  input  logic [15:0]         inPacket_tx_addr,
  input  logic [31:0]         inPacket_tx_data,
  output logic                link_valid,
  input  logic                link_ready,
  output logic [15:0]         link_beat,
  output logic                link_last,
  output logic                busy,
  output logic [COUNT_W-1:0]  sent_count
);

  tx_state_t            state_q, state_d;
  logic [BIDX_W-1:0]    beat_idx_q, beat_idx_d;
  packet_t              pkt_q, pkt_d;
  logic                 link_valid_q, link_valid_d;
  logic [BEAT_W-1:0]    link_beat_q, link_beat_d;
  logic                 link_last_q, link_last_d;
  logic [COUNT_W-1:0]   sent_count_q, sent_count_d;

  packet_t              in_pkt;
  logic                 in_ready;
  logic                 in_fire;
  logic                 beat_fire;
  logic                 on_last;
  logic [BIDX_W-1:0]    nxt_idx;

  assign in_pkt = '{header: inPacket_tx_header,
                    addr:   inPacket_tx_addr,
                    data:   inPacket_tx_data};

  always_comb begin
    on_last   = (beat_idx_q == LAST_IDX);
    beat_fire = link_valid_q && link_ready;
    // Ready is combinational on link_ready so the next packet can be latched
    // on the same edge that retires the current last beat.
    in_ready  = (state_q == IDLE) ||
                ((state_q == SEND) && on_last && link_ready);
    in_fire   = inPacket_valid && in_ready;
    nxt_idx   = beat_idx_q + BIDX_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    beat_idx_d   = beat_idx_q;
    pkt_d        = pkt_q;
    link_valid_d = link_valid_q;
    link_beat_d  = link_beat_q;
    link_last_d  = link_last_q;
    sent_count_d = sent_count_q;

    case (state_q)
      IDLE: begin
        if (in_fire) begin
          pkt_d        = in_pkt;
          beat_idx_d   = '0;
          link_valid_d = 1'b1;
          link_beat_d  = in_pkt.header;
          link_last_d  = 1'b0;
          state_d      = SEND;
        end
      end

      SEND: begin
        if (beat_fire) begin
          if (on_last) begin
            sent_count_d = sent_count_q + COUNT_W'(1);
            if (in_fire) begin
              // Chain straight into the next packet's header beat.
              pkt_d        = in_pkt;
              beat_idx_d   = '0;
              link_valid_d = 1'b1;
              link_beat_d  = in_pkt.header;
              link_last_d  = 1'b0;
            end else begin
              beat_idx_d   = '0;
              link_valid_d = 1'b0;
              link_last_d  = 1'b0;
              state_d      = IDLE;
            end
          end else begin
            beat_idx_d  = nxt_idx;
            link_beat_d = beat_of(pkt_q, nxt_idx);
            link_last_d = (nxt_idx == LAST_IDX);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_idx_q   <= '0;
      pkt_q        <= '0;
      link_valid_q <= 1'b0;
      link_beat_q  <= '0;
      link_last_q  <= 1'b0;
      sent_count_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_idx_q   <= beat_idx_d;
      pkt_q        <= pkt_d;
      link_valid_q <= link_valid_d;
      link_beat_q  <= link_beat_d;
      link_last_q  <= link_last_d;
      sent_count_q <= sent_count_d;
    end
  end

  assign inPacket_ready = in_ready;
  assign link_valid     = link_valid_q;
  assign link_beat      = link_beat_q;
  assign link_last      = link_last_q;
  assign busy           = (state_q == SEND);
  assign sent_count     = sent_count_q;

endmodule

// File: tb/tb_packet_tx_serializer.sv
// Randomized scoreboard bench for packet_tx_serializer (COUNT_W=2 to exercise wrap).
// Latency: n/a (testbench).
// Backpressure: link_ready driven forced-high, forced-low or random by mode.
`timescale 1ns/1ps
module tb_packet_tx_serializer;
  import packet_pkg::*;

  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          inPacket_valid = 1'b0;
  logic          inPacket_ready;
  logic [15:0]   inPacket_tx_header = '0;
  logic [15:0]   inPacket_tx_addr = '0;
  logic [31:0]   inPacket_tx_data = '0;
  logic          link_valid;
  logic          link_ready = 1'b1;
  logic [15:0]   link_beat;
  logic          link_last;
  logic          busy;
  logic [CW-1:0] sent_count;

  packet_tx_serializer #(.COUNT_W(CW)) dut (
    .clock              (clock),
    .reset              (reset),
    .inPacket_valid     (inPacket_valid),
    .inPacket_ready     (inPacket_ready),
    .inPacket_tx_header (inPacket_tx_header),
    .inPacket_tx_addr   (inPacket_tx_addr),
    .inPacket_tx_data   (inPacket_tx_data),
    .link_valid         (link_valid),
    .link_ready         (link_ready),
    .link_beat          (link_beat),
    .link_last          (link_last),
    .busy               (busy),
    .sent_count         (sent_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] beat;
    logic        last;
    int          avail;
  } exp_t;

  exp_t expq[$];
  int   cyc = 0;
  int   model_cnt = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   mon_en = 1'b0;
  int   rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else
      n_pass++;
  endtask

  // Reference: a packet becomes an ordered list of link words; the last one
  // is flagged and all are visible from the cycle after acceptance.
  function automatic void push_exp(input logic [15:0] h, input logic [15:0] a,
                                   input logic [31:0] d);
    logic [15:0] w[$];
    exp_t        e;
    w.push_back(h);
    w.push_back(a);
    w.push_back(d[31:16]);
    w.push_back(d[15:0]);
`ifdef PACKET_TX_CHECK_EN
    w.push_back(h ^ a ^ d[31:16] ^ d[15:0]);
`endif
    foreach (w[i]) begin
      e.beat  = w[i];
      e.last  = (i == w.size() - 1);
      e.avail = cyc + 1;
      expq.push_back(e);
    end
  endfunction

  // link_ready driver
  initial forever begin
    @(negedge clock);
    #1;
    case (rdy_mode)
      0:       link_ready = 1'b1;
      1:       link_ready = 1'b0;
      default: link_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: samples 3 time units after each falling edge.
  initial forever begin
    @(negedge clock);
    #3;
    if (mon_en) begin
      if (reset) begin
        expq.delete();
        model_cnt = 0;
      end else begin
        bit   exp_v;
        bit   exp_r;
        exp_t e;
        exp_v = 1'b0;
        exp_r = 1'b1;
        if (expq.size() > 0) begin
          if (expq[0].avail <= cyc) begin
            exp_v = 1'b1;
            exp_r = expq[0].last && link_ready;
          end
        end
        chk("link_valid", {31'b0, link_valid}, {31'b0, exp_v});
        chk("busy", {31'b0, busy}, {31'b0, exp_v});
        chk("inPacket_ready", {31'b0, inPacket_ready}, {31'b0, exp_r});
        chk("sent_count", {{(32-CW){1'b0}}, sent_count}, model_cnt % (1 << CW));
        if (exp_v && link_valid && link_ready) begin
          e = expq.pop_front();
          chk("link_beat", {16'b0, link_beat}, {16'b0, e.beat});
          chk("link_last", {31'b0, link_last}, {31'b0, e.last});
          if (e.last) model_cnt++;
        end
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send_pkt(input logic [15:0] h, input logic [15:0] a, input logic [31:0] d);
    bit got;
    got = 1'b0;
    inPacket_valid     = 1'b1;
    inPacket_tx_header = h;
    inPacket_tx_addr   = a;
    inPacket_tx_data   = d;
    for (int i = 0; i < 200; i++) begin
      #3;
      if (inPacket_ready && !reset) begin
        got = 1'b1;
        push_exp(h, a, d);
      end
      @(negedge clock);
      if (got) break;
    end
    inPacket_valid     = 1'b0;
    inPacket_tx_header = 16'($urandom);
    inPacket_tx_addr   = 16'($urandom);
    inPacket_tx_data   = $urandom;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (expq.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", expq.size(), 32'd0);
  endtask

  initial begin
    // Reset held over two rising edges.
    repeat (2) @(negedge clock);
    #3;
    chk("rst_link_valid", {31'b0, link_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, inPacket_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_sent_count", {{(32-CW){1'b0}}, sent_count}, 32'd0);
    chk("rst_link_beat", {16'b0, link_beat}, 32'd0);
    chk("rst_link_last", {31'b0, link_last}, 32'd0);
    @(negedge clock);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single packet, ready always high.
    send_pkt(16'hA5A5, 16'h0010, 32'hDEADBEEF);
    wait_drain();
    #3;
    chk("single_sent_count", {{(32-CW){1'b0}}, sent_count}, 32'd1);
    @(negedge clock);

    // Backpressure for three cycles while beat 2 is presented.
    send_pkt(16'hA5A5, 16'h0010, 32'hDEADBEEF);
    @(negedge clock);
    @(negedge clock);
    rdy_mode = 1;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("stall_beat", {16'b0, link_beat}, 32'h0000DEAD);
      chk("stall_valid", {31'b0, link_valid}, 32'd1);
      @(negedge clock);
    end
    rdy_mode = 0;
    wait_drain();

    // Back-to-back: second packet offered during the first one.
    send_pkt(16'hA5A5, 16'h0010, 32'hDEADBEEF);
    send_pkt(16'h1111, 16'h2222, 32'h33334444);
    wait_drain();

    // Counter wrap: five more packets with random content.
    for (int i = 0; i < 5; i++) begin
      send_pkt(16'($urandom), 16'($urandom), $urandom);
      wait_drain();
    end

`ifdef PACKET_TX_CHECK_EN
    send_pkt(16'h0001, 16'h0002, 32'h00040008);
    wait_drain();
`endif

    // Reset after beat 1 has been accepted.
    send_pkt(16'hCAFE, 16'hBABE, 32'h12345678);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #3;
    chk("midrst_link_valid", {31'b0, link_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, inPacket_ready}, 32'd1);
    chk("midrst_sent_count", {{(32-CW){1'b0}}, sent_count}, 32'd0);
    chk("midrst_link_beat", {16'b0, link_beat}, 32'd0);
    chk("midrst_link_last", {31'b0, link_last}, 32'd0);
    @(negedge clock);
    send_pkt(16'h0F0F, 16'hF0F0, 32'hA1B2C3D4);
    wait_drain();

    // Random traffic with random link backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      send_pkt(16'($urandom), 16'($urandom), $urandom);
    end
    rdy_mode = 0;
    wait_drain();
    repeat (3) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
